// File: rtl/vesa_timing_3840x2160_30hz_if.sv
// Video timing bundle: sync, enables and raster position from the timing generator.
interface vesa_timing_3840x2160_30hz_if;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        frame_valid;
    logic [15:0] h_count;
    logic [15:0] v_count;

    modport master (output hsync, vsync, de, frame_valid, h_count, v_count);
    modport slave  (input  hsync, vsync, de, frame_valid, h_count, v_count);
endinterface

// File: rtl/vesa_timing_3840x2160_30hz.sv
// 3840x2160@30Hz raster timing generator: free-running h/v counters with
// registered sync/enable outputs aligned to the counts they accompany.
module vesa_timing_3840x2160_30hz #(
    parameter int H_ACTIVE = 3840,
    parameter int H_FP     = 48,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 208,
    parameter int V_ACTIVE = 2160,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 31
) (
    input  logic                            clk,
    input  logic                            rst,
    vesa_timing_3840x2160_30hz_if.master    vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST    = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST    = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT_END = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT_END = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START  = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END    = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START  = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END    = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [15:0] h_count_q, h_count_d;
    logic [15:0] v_count_q, v_count_d;
    logic        de_q, de_d;
    logic        frame_valid_q, frame_valid_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        h_count_d = h_count_q + 16'd1;
        v_count_d = v_count_q;
        if (h_count_q == H_LAST) begin
            h_count_d = '0;
            v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 16'd1;
        end

        // Decode from the next counts so the registered flags line up with the registered counts.
        de_d          = (h_count_d < H_ACT_END) && (v_count_d < V_ACT_END);
        frame_valid_d = (v_count_d < V_ACT_END);
        hsync_d       = (h_count_d >= HS_START) && (h_count_d < HS_END);
        vsync_d       = !((v_count_d >= VS_START) && (v_count_d < VS_END));
    end

    // NOTE: reset parks the raster on its last position, so the first edge after release lands on pixel 0,0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_count_q     <= H_LAST;
            v_count_q     <= V_LAST;
            de_q          <= 1'b0;
            frame_valid_q <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            de_q          <= de_d;
            frame_valid_q <= frame_valid_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
        end
    end

    assign vid.h_count     = h_count_q;
    assign vid.v_count     = v_count_q;
    assign vid.de          = de_q;
    assign vid.frame_valid = frame_valid_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
endmodule

// File: tb/tb_vesa_timing_3840x2160_30hz.sv
// Bench: full-size instance for reset and line timing, shrunken instance for
// frame, wrap, blanking and random mid-frame resets against a position model.
module tb_vesa_timing_3840x2160_30hz;
    localparam int S_HA = 40, S_HF = 4, S_HS = 3, S_HB = 5;
    localparam int S_VA = 12, S_VF = 2, S_VS = 3, S_VB = 4;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FT = S_HT * S_VT;

    logic clk = 1'b0;
    logic rst_d;
    logic rst_s;
    int   tests = 0;
    int   fails = 0;
    int   n_s   = 0;

    always #5 clk = ~clk;

    vesa_timing_3840x2160_30hz_if vif();
    vesa_timing_3840x2160_30hz_if sif();

    vesa_timing_3840x2160_30hz dut (.clk(clk), .rst(rst_d), .vid(vif));

    vesa_timing_3840x2160_30hz #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) dut_s (.clk(clk), .rst(rst_s), .vid(sif));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            if (fails <= 20) $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected outputs of the small instance: reset park position, or the raster
    // position reached after n_s edges since release, decoded from the timing rules.
    task automatic check_s(input string ph);
        int p, h, v;
        logic ede, efv, ehs, evs;
        if (rst_s) begin
            h = S_HT - 1; v = S_VT - 1;
            ede = 1'b0; efv = 1'b0; ehs = 1'b0; evs = 1'b1;
        end else begin
            p   = (n_s - 1) % S_FT;
            h   = p % S_HT;
            v   = p / S_HT;
            ede = (h < S_HA) && (v < S_VA);
            efv = (v < S_VA);
            ehs = (h >= S_HA + S_HF) && (h < S_HA + S_HF + S_HS);
            evs = !((v >= S_VA + S_VF) && (v < S_VA + S_VF + S_VS));
        end
        check({ph, "_h"},  sif.h_count, h);
        check({ph, "_v"},  sif.v_count, v);
        check({ph, "_de"}, sif.de, ede);
        check({ph, "_fv"}, sif.frame_valid, efv);
        check({ph, "_hs"}, sif.hsync, ehs);
        check({ph, "_vs"}, sif.vsync, evs);
    endtask

    task automatic cyc(input string ph);
        @(posedge clk);
        if (rst_s) n_s = 0;
        else       n_s++;
        @(negedge clk);
        check_s(ph);
    endtask

    // Async reset asserted between edges, checked before any edge, then held and released.
    task automatic mid_reset(input int hold);
        #2;
        rst_s = 1'b1;
        n_s   = 0;
        #1;
        check_s("async_rst");
        repeat (hold) cyc("rst_hold");
        rst_s = 1'b0;
        cyc("after_rst");
        check("restart_h0", sif.h_count, 0);
        check("restart_v0", sif.v_count, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete, observed hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int h_bad, de_cnt, hs_cnt, hs_first;
        int vs_low, blank_de, blank_fv, blank_hs;
        int falls[$];
        logic prev_vs, prev_hs, found;

        rst_d = 1'b1;
        rst_s = 1'b1;
        #1;
        check("rst_async_h", vif.h_count, 4127);
        check("rst_async_v", vif.v_count, 2198);
        repeat (10) @(negedge clk);
        check("rst_h",  vif.h_count, 4127);
        check("rst_v",  vif.v_count, 2198);
        check("rst_de", vif.de, 0);
        check("rst_fv", vif.frame_valid, 0);
        check("rst_hs", vif.hsync, 0);
        check("rst_vs", vif.vsync, 1);

        rst_d = 1'b0;
        @(negedge clk);
        check("first_h",  vif.h_count, 0);
        check("first_v",  vif.v_count, 0);
        check("first_de", vif.de, 1);
        check("first_fv", vif.frame_valid, 1);

        h_bad = 0; de_cnt = 0; hs_cnt = 0; hs_first = -1;
        for (int i = 0; i < 4128; i++) begin
            if (vif.h_count != 16'(i) || vif.v_count != 16'd0) h_bad++;
            if (vif.de) de_cnt++;
            if (vif.hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
            end
            @(negedge clk);
        end
        check("line_count_seq", h_bad, 0);
        check("line_de_cycles", de_cnt, 3840);
        check("line_hs_cycles", hs_cnt, 32);
        check("line_hs_start",  hs_first, 3888);
        check("line_period_h",  vif.h_count, 0);
        check("line_period_v",  vif.v_count, 1);

        check_s("s_rst");
        rst_s = 1'b0;
        vs_low = 0; blank_de = 0; blank_fv = 0; blank_hs = 0;
        prev_vs = 1'b1; prev_hs = 1'b0;
        for (int i = 0; i < 3 * S_FT + 5; i++) begin
            cyc("frame");
            if (prev_vs && !sif.vsync) begin
                falls.push_back(i);
                check("vs_fall_h", sif.h_count, 0);
                check("vs_fall_v", sif.v_count, S_VA + S_VF);
            end
            if (!sif.vsync) vs_low++;
            if (sif.v_count >= 16'(S_VA)) begin
                if (sif.de) blank_de++;
                if (sif.frame_valid) blank_fv++;
                if (sif.hsync && !prev_hs) blank_hs++;
            end
            prev_vs = sif.vsync;
            prev_hs = sif.hsync;
        end
        check("vs_fall_count", falls.size(), 3);
        if (falls.size() == 3) begin
            check("vs_period_0", falls[1] - falls[0], S_FT);
            check("vs_period_1", falls[2] - falls[1], S_FT);
        end
        check("vs_low_cycles", vs_low, 3 * S_VS * S_HT);
        check("blank_de",      blank_de, 0);
        check("blank_fv",      blank_fv, 0);
        check("blank_hs_per_line", blank_hs, 3 * (S_VT - S_VA));

        found = 1'b0;
        for (int i = 0; i < 2 * S_FT && !found; i++) begin
            if (sif.h_count == 16'(S_HT - 1) && sif.v_count == 16'(S_VT - 1)) found = 1'b1;
            else cyc("seek_wrap");
        end
        check("wrap_found", found, 1);
        cyc("wrap");
        check("wrap_h",  sif.h_count, 0);
        check("wrap_v",  sif.v_count, 0);
        check("wrap_de", sif.de, 1);
        check("wrap_fv", sif.frame_valid, 1);

        found = 1'b0;
        for (int i = 0; i < 2 * S_FT && !found; i++) begin
            if (sif.h_count == 16'd25 && sif.v_count == 16'd6) found = 1'b1;
            else cyc("seek_mid");
        end
        check("mid_found", found, 1);
        mid_reset(3);

        repeat (6) begin
            int run;
            run = int'($urandom_range(1, 2 * S_FT));
            repeat (run) cyc("rand_run");
            mid_reset(int'($urandom_range(1, 5)));
        end
        repeat (S_FT + 3) cyc("final_run");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
